// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter
// Iterative AES decryptor for 128/192/256-bit keys. The key schedule is
// expanded once (one word per clock) into an internal store and reused for
// every block until a new key is accepted; blocks decrypt at one round per
// clock.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_key_valid / o_key_ready   key handshake; i_key_len 0=128 1=192 2=256
//   i_key[255:0]                left-aligned cipher key
//   i_in_valid / o_in_ready     ciphertext handshake, i_in_data[127:0]
//   o_out_valid / i_out_ready   plaintext handshake, o_out_data[127:0]
//   o_key_ok                    a complete schedule is stored
//   o_err_len                   sticky illegal-key-length flag
module aes_inv_cipher_iter #(
  parameter bit SUPPORT_256 = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_key_valid,
  output logic         o_key_ready,
  input  logic [1:0]   i_key_len,
  input  logic [255:0] i_key,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_in_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_out_data,
  output logic         o_key_ok,
  output logic         o_err_len
);

  localparam int unsigned NW = SUPPORT_256 ? 60 : 52;

  typedef enum logic [2:0] {
    S_NOKEY,
    S_EXPAND,
    S_READY,
    S_ROUND,
    S_HOLD
  } state_t;

  // ---------------------------------------------------------------- GF(2^8)
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    logic [7:0] m;
    p = '0;
    t = a;
    m = b;
    for (int unsigned k = 0; k < 8; k++) begin
      if (m[0]) p = p ^ t;
      t = xtime(t);
      m = m >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gmul(gmul(x, x), x);
    x7   = gmul(gmul(x3, x3), x);
    x15  = gmul(gmul(x7, x7), x);
    x31  = gmul(gmul(x15, x15), x);
    x63  = gmul(gmul(x31, x31), x);
    x127 = gmul(gmul(x63, x63), x);
    return gmul(x127, x127);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int unsigned n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-boxes computed from the field inverse and the affine map rather than
  // stored as tables.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = ginv(x);
    return y ^ rl(y, 1) ^ rl(y, 2) ^ rl(y, 3) ^ rl(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv(rl(x, 1) ^ rl(x, 3) ^ rl(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // InvShiftRows followed by InvSubBytes; byte n = row + 4*col, byte 0 at MSB.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    int unsigned  src;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        src = r + 4 * ((c + 4 - r) % 4);
        o[127 - 8 * (r + 4 * c) -: 8] = inv_sbox(s[127 - 8 * src -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction

  // ---------------------------------------------------------------- state
  state_t       r_fsm, w_fsm_nxt;
  logic [31:0]  r_w [0:NW-1];
  logic [3:0]   r_nk, r_nr, r_round;
  logic [5:0]   r_idx;
  logic [2:0]   r_kmod;        // i mod Nk, kept as a wrapping counter
  logic [7:0]   r_rcon;
  logic [31:0]  r_prev;        // w[i-1]
  logic [127:0] r_state, r_out;
  logic         r_out_valid, r_key_ok, r_err_len;

  logic         w_len_ok, w_key_fire, w_in_fire, w_last;
  logic [3:0]   w_nk_sel, w_nr_sel, w_rk_sel;
  logic [31:0]  w_key_last, w_temp, w_new_word;
  logic [5:0]   w_back_idx, w_last_idx, w_rk_base;
  logic [127:0] w_rk, w_ark, w_round_out;

  assign o_key_ready = (r_fsm == S_NOKEY) || (r_fsm == S_READY);
  assign o_in_ready  = (r_fsm == S_READY) && !i_key_valid;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out;
  assign o_key_ok    = r_key_ok;
  assign o_err_len   = r_err_len;

  assign w_key_fire = i_key_valid && o_key_ready;
  assign w_in_fire  = i_in_valid && o_in_ready;

  always_comb begin
    w_len_ok   = 1'b0;
    w_nk_sel   = 4'd4;
    w_nr_sel   = 4'd10;
    w_key_last = i_key[159:128];
    case (i_key_len)
      2'd0: w_len_ok = 1'b1;
      2'd1: begin
        w_len_ok   = 1'b1;
        w_nk_sel   = 4'd6;
        w_nr_sel   = 4'd12;
        w_key_last = i_key[95:64];
      end
      2'd2: begin
        w_len_ok   = SUPPORT_256;
        w_nk_sel   = 4'd8;
        w_nr_sel   = 4'd14;
        w_key_last = i_key[31:0];
      end
      default: w_len_ok = 1'b0;
    endcase
  end

  // Key expansion: w[i] = w[i-Nk] ^ f(w[i-1])
  assign w_back_idx = r_idx - {2'b00, r_nk};
  assign w_last_idx = {r_nr, 2'b11};           // 4*(Nr+1)-1
  assign w_last     = (r_idx == w_last_idx);

  always_comb begin
    w_temp = r_prev;
    if (r_kmod == 3'd0)
      w_temp = sub_word({r_prev[23:0], r_prev[31:24]}) ^ {r_rcon, 24'h000000};
    else if ((r_nk == 4'd8) && (r_kmod == 3'd4))
      w_temp = sub_word(r_prev);
  end

  assign w_new_word = r_w[w_back_idx] ^ w_temp;

  // Round key: rk[Nr] for the initial whitening in READY, rk[r] in ROUND.
  assign w_rk_sel  = (r_fsm == S_ROUND) ? r_round : r_nr;
  assign w_rk_base = {w_rk_sel, 2'b00};
  assign w_rk      = {r_w[w_rk_base], r_w[w_rk_base + 6'd1],
                      r_w[w_rk_base + 6'd2], r_w[w_rk_base + 6'd3]};

  assign w_ark       = inv_shift_sub(r_state) ^ w_rk;
  assign w_round_out = (r_round == 4'd0) ? w_ark : inv_mix(w_ark);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= S_NOKEY;
    else        r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_NOKEY: begin
        if (w_key_fire) w_fsm_nxt = w_len_ok ? S_EXPAND : S_NOKEY;
      end
      S_EXPAND: begin
        if (w_last) w_fsm_nxt = S_READY;
      end
      S_READY: begin
        if (w_key_fire)     w_fsm_nxt = w_len_ok ? S_EXPAND : S_NOKEY;
        else if (w_in_fire) w_fsm_nxt = S_ROUND;
      end
      S_ROUND: begin
        if (r_round == 4'd0) w_fsm_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (i_out_ready) w_fsm_nxt = S_READY;
      end
      default: w_fsm_nxt = S_NOKEY;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nk        <= 4'd4;
      r_nr        <= 4'd10;
      r_idx       <= '0;
      r_kmod      <= '0;
      r_rcon      <= 8'h01;
      r_prev      <= '0;
      r_round     <= '0;
      r_state     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_key_ok    <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      case (r_fsm)
        S_NOKEY, S_READY: begin
          if (w_key_fire) begin
            r_key_ok <= 1'b0;
            if (w_len_ok) begin
              r_err_len <= 1'b0;
              r_nk      <= w_nk_sel;
              r_nr      <= w_nr_sel;
              r_idx     <= {2'b00, w_nk_sel};
              r_kmod    <= '0;
              r_rcon    <= 8'h01;
              r_prev    <= w_key_last;
            end else begin
              r_err_len <= 1'b1;
            end
          end else if (w_in_fire) begin
            r_state <= i_in_data ^ w_rk;
            r_round <= r_nr - 4'd1;
          end
        end
        S_EXPAND: begin
          r_prev <= w_new_word;
          r_idx  <= r_idx + 6'd1;
          r_kmod <= ({1'b0, r_kmod} == r_nk - 4'd1) ? 3'd0 : r_kmod + 3'd1;
          if (r_kmod == 3'd0) r_rcon <= xtime(r_rcon);
          if (w_last) r_key_ok <= 1'b1;
        end
        S_ROUND: begin
          r_state <= w_round_out;
          r_round <= r_round - 4'd1;
          if (r_round == 4'd0) begin
            r_out       <= w_round_out;
            r_out_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (i_out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Schedule store carries no reset; o_key_ok qualifies its contents.
  always_ff @(posedge clk) begin
    if (w_key_fire && w_len_ok) begin
      for (int unsigned j = 0; j < 8; j++) begin
        if (j < 32'(w_nk_sel)) r_w[j[5:0]] <= i_key[255 - 32 * j -: 32];
      end
    end else if (r_fsm == S_EXPAND) begin
      r_w[r_idx] <= w_new_word;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
module tb_aes_inv_cipher_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         key_valid, key_ready, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic [127:0] in_data, out_data;
  logic         key_ok, err_len;

  // second instance built without 256-bit support
  logic         b_key_valid, b_key_ready, b_in_valid, b_in_ready, b_out_valid;
  logic [1:0]   b_key_len;
  logic [255:0] b_key;
  logic [127:0] b_in_data, b_out_data;
  logic         b_key_ok, b_err_len;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KNIST = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] ECB_C1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] ECB_P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] ECB_C2 = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] ECB_P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] ECB_C3 = 128'h43b1cd7f598ece23881b00e3ed030688;
  localparam logic [127:0] ECB_P3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;

  aes_inv_cipher_iter #(.SUPPORT_256(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_key_valid(key_valid), .o_key_ready(key_ready),
    .i_key_len(key_len), .i_key(key),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_key_ok(key_ok), .o_err_len(err_len)
  );

  aes_inv_cipher_iter #(.SUPPORT_256(1'b0)) u_dut_n256 (
    .clk(clk), .rst_n(rst_n),
    .i_key_valid(b_key_valid), .o_key_ready(b_key_ready),
    .i_key_len(b_key_len), .i_key(b_key),
    .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_data(b_in_data),
    .o_out_valid(b_out_valid), .i_out_ready(1'b1), .o_out_data(b_out_data),
    .o_key_ok(b_key_ok), .o_err_len(b_err_len)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_key(input logic [1:0] len, input logic [255:0] k,
                          input int setup, input string tag);
    int n;
    key_valid = 1'b1;
    key_len   = len;
    key       = k;
    n = 0;
    while (!key_ready && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk({tag, "_keyok_low"}, key_ok, 1'b0);
    chk({tag, "_keyrdy_expand"}, key_ready, 1'b0);
    chk({tag, "_inrdy_expand"}, in_ready, 1'b0);
    chk({tag, "_errlen_clr"}, err_len, 1'b0);
    n = 0;
    while (!key_ok && n < 200) begin @(posedge clk); #1; n++; end
    chk({tag, "_setup"}, 128'(n), 128'(setup));
  endtask

  task automatic decrypt(input logic [127:0] ct, input logic [127:0] pt,
                         input int nr, input string tag);
    int n;
    in_valid = 1'b1;
    in_data  = ct;
    n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk({tag, "_latency"}, 128'(n), 128'(nr));
    chk({tag, "_pt"}, out_data, pt);
    if (out_ready) begin
      @(posedge clk); #1;
      chk({tag, "_ovalid_drop"}, out_valid, 1'b0);
      chk({tag, "_inrdy_back"}, in_ready, 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    key_valid = 1'b0; key_len = 2'd0; key = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    b_key_valid = 1'b0; b_key_len = 2'd0; b_key = '0;
    b_in_valid = 1'b0; b_in_data = '0;

    repeat (2) @(posedge clk); #1;
    chk("rst_key_ready", key_ready, 1'b1);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_key_ok", key_ok, 1'b0);
    chk("rst_err_len", err_len, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 example vectors, all three key lengths
    load_key(2'd0, K128, 40, "k128");
    decrypt(CT128, PT, 10, "aes128");
    load_key(2'd1, K192, 46, "k192");
    decrypt(CT192, PT, 12, "aes192");
    load_key(2'd2, K256, 52, "k256");
    decrypt(CT256, PT, 14, "aes256");

    // 256-bit key offered to the instance without 256 support
    b_key_valid = 1'b1; b_key_len = 2'd2; b_key = K256;
    b_in_valid = 1'b1; b_in_data = CT256;
    @(posedge clk); #1;
    b_key_valid = 1'b0;
    chk("n256_err_len", b_err_len, 1'b1);
    chk("n256_key_ok", b_key_ok, 1'b0);
    chk("n256_in_ready", b_in_ready, 1'b0);
    repeat (60) @(posedge clk); #1;
    chk("n256_key_ok_late", b_key_ok, 1'b0);
    chk("n256_in_ready_late", b_in_ready, 1'b0);
    chk("n256_key_ready", b_key_ready, 1'b1);
    chk("n256_out_valid", b_out_valid, 1'b0);
    b_in_valid = 1'b0;

    // Stream three blocks, back-pressure on the second
    load_key(2'd0, KNIST, 40, "knist");
    decrypt(ECB_C1, ECB_P1, 10, "ecb1");
    out_ready = 1'b0;
    decrypt(ECB_C2, ECB_P2, 10, "ecb2");
    in_valid = 1'b1;
    in_data  = ECB_C3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_data", out_data, ECB_P2);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ovalid", out_valid, 1'b0);
    chk("bp_release_inrdy", in_ready, 1'b1);
    decrypt(ECB_C3, ECB_P3, 10, "ecb3");

    // Key and data offered together: key wins, block waits for new schedule
    key_valid = 1'b1; key_len = 2'd1; key = K192;
    in_valid  = 1'b1; in_data = CT192;
    #1;
    chk("arb_in_ready", in_ready, 1'b0);
    chk("arb_key_ready", key_ready, 1'b1);
    load_key(2'd1, K192, 46, "arb_k192");
    decrypt(CT192, PT, 12, "arb_aes192");

    // Reset in the middle of a decryption
    in_valid = 1'b1; in_data = CT192;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("abort_busy", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_key_ready", key_ready, 1'b1);
    chk("abort_in_ready", in_ready, 1'b0);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_out_data", out_data, '0);
    chk("abort_key_ok", key_ok, 1'b0);
    chk("abort_err_len", err_len, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_key_ok_after", key_ok, 1'b0);
    load_key(2'd0, K128, 40, "reload128");
    decrypt(CT128, PT, 10, "reload_aes128");

    // Reserved key length
    key_valid = 1'b1; key_len = 2'd3; key = K128;
    @(posedge clk); #1;
    key_valid = 1'b0;
    in_valid = 1'b1; in_data = CT128;
    #1;
    chk("ill_err_len", err_len, 1'b1);
    chk("ill_key_ok", key_ok, 1'b0);
    chk("ill_key_ready", key_ready, 1'b1);
    chk("ill_in_ready", in_ready, 1'b0);
    repeat (3) @(posedge clk); #1;
    chk("ill_out_valid", out_valid, 1'b0);
    chk("ill_err_sticky", err_len, 1'b1);
    in_valid = 1'b0;
    load_key(2'd0, K128, 40, "legal_after_ill");
    decrypt(CT128, PT, 10, "after_ill_aes128");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
